// File: rtl/sar_pkg.sv
// Shared encodings for the successive-approximation search controller:
// FSM state codes and the one-hot {greater,equal,less} flag patterns.
package sar_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PROBE  = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        PROBE  = ST_PROBE,
        VERIFY = ST_VERIFY,
        DONE   = ST_DONE
    } sar_state_t;

    localparam logic [2:0] FLAG_GT = 3'b100;
    localparam logic [2:0] FLAG_EQ = 3'b010;
    localparam logic [2:0] FLAG_LT = 3'b001;

endpackage

// File: rtl/sar_search_ctrl.sv
// MSB-first binary search controller driving an external magnitude comparator
// (A = trial, B = unknown target) and recovering the target from its flags.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             greater,
    input  logic             equal,
    input  logic             less,
    output logic             cmp_en,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    sar_state_t       state;
    logic [WIDTH-1:0] mask;
    logic [2:0]       flags;
    logic             flags_ok;
    logic [WIDTH-1:0] next_mask;
    logic [WIDTH-1:0] next_trial;

    // When mask was bit 0 the shifted mask is zero, so next_trial is simply
    // the decided value that VERIFY must confirm.
    always_comb begin
        flags      = {greater, equal, less};
        flags_ok   = (flags == FLAG_GT) || (flags == FLAG_EQ) || (flags == FLAG_LT);
        next_mask  = mask >> 1;
        next_trial = (greater ? (trial & ~mask) : trial) | next_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mask   <= '0;
            cmp_en <= 1'b0;
            trial  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        trial  <= MSB;
                        mask   <= MSB;
                        busy   <= 1'b1;
                        cmp_en <= 1'b1;
                        result <= '0;
                        found  <= 1'b0;
                        err    <= 1'b0;
                        state  <= PROBE;
                    end else begin
                        trial  <= '0;
                        cmp_en <= 1'b0;
                    end
                end
                PROBE: begin
                    if (!flags_ok || equal) begin
                        err    <= !flags_ok;
                        found  <= flags_ok;
                        result <= trial;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        cmp_en <= 1'b0;
                        state  <= DONE;
                    end else begin
                        trial <= next_trial;
                        mask  <= next_mask;
                        if (next_mask == '0) begin
                            state <= VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    err    <= !flags_ok;
                    found  <= flags_ok && equal;
                    result <= trial;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    cmp_en <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: behavioural comparator plus an
// arithmetic model of the expected probe sequence for random targets.
module tb_sar_search_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             greater;
    logic             equal;
    logic             less;
    logic             cmp_en;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;

    int         target;
    logic       force_en;
    logic [2:0] force_val;
    int         errors;
    int         checks;

    sar_search_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .greater(greater),
        .equal  (equal),
        .less   (less),
        .cmp_en (cmp_en),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator with A = trial, B = target, gated by cmp_en; can be overridden
    // to inject illegal flag patterns.
    always_comb begin
        if (force_en) begin
            {greater, equal, less} = force_val;
        end else if (cmp_en) begin
            greater = int'(trial) > target;
            equal   = int'(trial) == target;
            less    = int'(trial) < target;
        end else begin
            {greater, equal, less} = 3'b000;
        end
    end

    // Number of comparisons a binary search needs: it stops as soon as the
    // trial reaches the target, i.e. at the target's lowest set bit; a zero
    // target needs every bit cleared plus one verifying compare.
    function automatic int model_probes(input int tgt);
        int tz;
        if (tgt == 0) return WIDTH + 1;
        tz = 0;
        while ((tgt % 2) == 0) begin
            tgt = tgt / 2;
            tz++;
        end
        return WIDTH - tz;
    endfunction

    // Trial at probe k: target's bits above the bit under test, plus that bit set.
    function automatic int model_trial(input int tgt, input int k);
        int b;
        if (k >= WIDTH) return (tgt / 2) * 2;
        b = WIDTH - 1 - k;
        return ((tgt / (2 ** (b + 1))) * (2 ** (b + 1))) + (2 ** b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_search(input int tgt, input bit hold_start, input string name);
        int  n_exp;
        int  k;
        int  budget;
        bit  seen_done;
        target    = tgt;
        n_exp     = model_probes(tgt);
        k         = 0;
        seen_done = 1'b0;
        budget    = WIDTH + 6;
        start     = 1'b1;
        tick();
        while (!seen_done && budget > 0) begin
            budget--;
            if (done) begin
                seen_done = 1'b1;
                start     = 1'b0;
                checks++;
                if (k !== n_exp) begin
                    errors++;
                    $display("[TB] FAIL %s probes: got %0d expected %0d", name, k, n_exp);
                end
                checks++;
                if ({result, found, err, busy, cmp_en} !== {WIDTH'(tgt), 4'b1000}) begin
                    errors++;
                    $display("[TB] FAIL %s done outputs: got result=%0d found=%b err=%b busy=%b cmp_en=%b expected result=%0d found=1 err=0 busy=0 cmp_en=0",
                             name, result, found, err, busy, cmp_en, tgt);
                end
            end else begin
                start = hold_start;
                checks++;
                if ({busy, cmp_en, trial} !== {2'b11, WIDTH'(model_trial(tgt, k))}) begin
                    errors++;
                    $display("[TB] FAIL %s probe %0d: got busy=%b cmp_en=%b trial=%0d expected busy=1 cmp_en=1 trial=%0d",
                             name, k, busy, cmp_en, trial, model_trial(tgt, k));
                end
                k++;
                tick();
            end
        end
        start = 1'b0;
        if (!seen_done) begin
            errors++;
            $display("[TB] FAIL %s timeout: got no done expected done after %0d probes", name, n_exp);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL %s after done: got done=%b busy=%b expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({cmp_en, trial, busy, done, result, found, err} !== '0) begin
                errors++;
                $display("[TB] FAIL reset cycle %0d: got cmp_en=%b trial=%0d busy=%b done=%b result=%0d found=%b err=%b expected all 0",
                         i, cmp_en, trial, busy, done, result, found, err);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        run_search(15, 1'b0, "target15");
        run_search(0, 1'b0, "target0");
        run_search(5, 1'b0, "target5");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_search(int'($urandom_range(0, 2 ** WIDTH - 1)), 1'b0, "random");
        end
    endtask

    task automatic test_bad_flags();
        logic [2:0] pats [2];
        pats[0] = 3'b000;
        pats[1] = 3'b110;
        for (int i = 0; i < 2; i++) begin
            target    = 9;
            force_en  = 1'b1;
            force_val = pats[i];
            start     = 1'b1;
            tick();
            start = 1'b0;
            tick();
            checks++;
            if ({done, err, found, result} !== {3'b110, WIDTH'(8)}) begin
                errors++;
                $display("[TB] FAIL badflags %b: got done=%b err=%b found=%b result=%0d expected done=1 err=1 found=0 result=8",
                         pats[i], done, err, found, result);
            end
            force_en = 1'b0;
            tick();
        end
        start = 1'b1;
        target = 3;
        tick();
        start = 1'b0;
        checks++;
        if ({err, found} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL accept clears err/found: got err=%b found=%b expected 0 0", err, found);
        end
        while (busy) tick();
        tick();
    endtask

    task automatic test_back_to_back();
        run_search(5, 1'b1, "start_while_busy");
        run_search(int'($urandom_range(1, 2 ** WIDTH - 1)), 1'b1, "start_while_busy_rand");
    endtask

    task automatic test_reset_mid_search();
        target = 5;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({cmp_en, trial, busy, done, result, found, err} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset: got cmp_en=%b trial=%0d busy=%b done=%b result=%0d expected all 0",
                     cmp_en, trial, busy, done, result);
        end
        tick();
        checks++;
        if ({busy, done, cmp_en} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL midreset idle: got busy=%b done=%b cmp_en=%b expected 0 0 0", busy, done, cmp_en);
        end
        run_search(5, 1'b0, "after_reset");
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        target    = 0;
        force_en  = 1'b0;
        force_val = 3'b000;
        test_reset();
        test_directed();
        test_random();
        test_bad_flags();
        test_back_to_back();
        test_reset_mid_search();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
